// File: rtl/maxnet_scheduler.sv
// Round-robin front end that shares one Maxnet engine among four requesters.
// Grants one requester, starts the engine, waits for done under a watchdog, then answers.
module maxnet_scheduler #(
    parameter int W       = 5,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [16*W-1:0]   req_data,
    output logic [3:0]        gnt,
    output logic              busy,
    output logic              mx_start,
    output logic [W-1:0]      mx_X1,
    output logic [W-1:0]      mx_X2,
    output logic [W-1:0]      mx_X3,
    output logic [W-1:0]      mx_X4,
    input  logic              mx_done,
    input  logic [W-1:0]      mx_result,
    output logic              rsp_valid,
    output logic [1:0]        rsp_id,
    output logic [W-1:0]      rsp_result,
    output logic              rsp_timeout
);

    localparam int WCW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t         r_state, w_state_next;
    logic [1:0]     r_ptr, w_ptr_next;
    logic [WCW-1:0] r_wcnt, w_wcnt_next;
    logic [3:0]     r_gnt, w_gnt_next;
    logic           r_busy, w_busy_next;
    logic           r_mx_start, w_mx_start_next;
    logic [4*W-1:0] r_ops, w_ops_next;
    logic           r_rsp_valid, w_rsp_valid_next;
    logic [1:0]     r_rsp_id, w_rsp_id_next;
    logic [W-1:0]   r_rsp_result, w_rsp_result_next;
    logic           r_rsp_timeout, w_rsp_timeout_next;

    logic [4*W-1:0] w_slot [4];
    logic [1:0]     w_win;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            assign w_slot[gi] = req_data[4*W*gi +: 4*W];
        end
    endgenerate

    // Scan offsets from far to near so the nearest requester above ptr wins.
    always_comb begin
        w_win = r_ptr;
        for (int i = 4; i >= 1; i--) begin
            if (req[r_ptr + 2'(i)]) begin
                w_win = r_ptr + 2'(i);
            end
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_ptr_next         = r_ptr;
        w_wcnt_next        = r_wcnt;
        w_gnt_next         = 4'b0000;
        w_mx_start_next    = 1'b0;
        w_ops_next         = r_ops;
        w_rsp_valid_next   = 1'b0;
        w_rsp_id_next      = r_rsp_id;
        w_rsp_result_next  = r_rsp_result;
        w_rsp_timeout_next = r_rsp_timeout;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_next    = S_START;
                    w_ptr_next      = w_win;
                    w_ops_next      = w_slot[w_win];
                    w_rsp_id_next   = w_win;
                    w_gnt_next      = 4'b0001 << w_win;
                    w_mx_start_next = 1'b1;
                end
            end
            S_START: begin
                w_state_next = S_WAIT;
                w_wcnt_next  = '0;
            end
            S_WAIT: begin
                // The first WAIT cycle may still see the engine's previous done.
                if (mx_done && (r_wcnt != '0)) begin
                    w_state_next       = S_RESP;
                    w_rsp_valid_next   = 1'b1;
                    w_rsp_result_next  = mx_result;
                    w_rsp_timeout_next = 1'b0;
                end else if (r_wcnt == WCW'(TIMEOUT - 1)) begin
                    w_state_next       = S_RESP;
                    w_rsp_valid_next   = 1'b1;
                    w_rsp_result_next  = '0;
                    w_rsp_timeout_next = 1'b1;
                end else begin
                    w_wcnt_next = r_wcnt + WCW'(1);
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        w_busy_next = (w_state_next != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_ptr         <= 2'd3;
            r_wcnt        <= '0;
            r_gnt         <= 4'b0000;
            r_busy        <= 1'b0;
            r_mx_start    <= 1'b0;
            r_ops         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= 2'd0;
            r_rsp_result  <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_ptr         <= w_ptr_next;
            r_wcnt        <= w_wcnt_next;
            r_gnt         <= w_gnt_next;
            r_busy        <= w_busy_next;
            r_mx_start    <= w_mx_start_next;
            r_ops         <= w_ops_next;
            r_rsp_valid   <= w_rsp_valid_next;
            r_rsp_id      <= w_rsp_id_next;
            r_rsp_result  <= w_rsp_result_next;
            r_rsp_timeout <= w_rsp_timeout_next;
        end
    end

    assign gnt         = r_gnt;
    assign busy        = r_busy;
    assign mx_start    = r_mx_start;
    assign mx_X1       = r_ops[0*W +: W];
    assign mx_X2       = r_ops[1*W +: W];
    assign mx_X3       = r_ops[2*W +: W];
    assign mx_X4       = r_ops[3*W +: W];
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_result  = r_rsp_result;
    assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_maxnet_scheduler.sv
// Bench for maxnet_scheduler: vector table, directed corner sequences and a
// randomized run against a cycle-level reference model with a behavioural engine.
module tb_maxnet_scheduler;

    localparam int W  = 5;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    req = 4'b0000;
    logic [16*W-1:0] req_data = '0;
    logic [3:0]    gnt;
    logic          busy;
    logic          mx_start;
    logic [W-1:0]  mx_X1, mx_X2, mx_X3, mx_X4;
    logic          mx_done;
    logic [W-1:0]  mx_result;
    logic          rsp_valid;
    logic [1:0]    rsp_id;
    logic [W-1:0]  rsp_result;
    logic          rsp_timeout;

    int tests = 0;
    int fails = 0;

    maxnet_scheduler #(.W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt), .busy(busy), .mx_start(mx_start),
        .mx_X1(mx_X1), .mx_X2(mx_X2), .mx_X3(mx_X3), .mx_X4(mx_X4),
        .mx_done(mx_done), .mx_result(mx_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    // Behavioural engine: done is a level that stays up until one cycle after the next start.
    logic          eng_done = 1'b0;
    logic [W-1:0]  eng_res = '0;
    logic          eng_busy = 1'b0;
    int            eng_cnt = 0;
    int            eng_lat = 1;
    bit            eng_hang = 1'b0;
    bit            stale_force = 1'b0;

    assign mx_done   = eng_done | stale_force;
    assign mx_result = eng_res;

    function automatic logic [W-1:0] max4(input logic [4*W-1:0] ops);
        logic [W-1:0] m;
        m = ops[W-1:0];
        for (int k = 1; k < 4; k++)
            if (ops[k*W +: W] > m) m = ops[k*W +: W];
        return m;
    endfunction

    always @(posedge clk) begin
        if (mx_start) begin
            eng_busy <= 1'b1;
            eng_cnt  <= 0;
        end else if (eng_busy) begin
            eng_cnt <= eng_cnt + 1;
            if (eng_cnt == 0) eng_done <= 1'b0;
            if (!eng_hang && (eng_cnt + 1 == eng_lat)) begin
                eng_done <= 1'b1;
                eng_res  <= max4({mx_X4, mx_X3, mx_X2, mx_X1});
                eng_busy <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return p;
    endfunction

    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == 4'b0000 && n < 30);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    typedef struct {
        logic [3:0]     req;
        logic [4*W-1:0] ops;
        int             lat;
        bit             hang;
        int             exp_id;
        logic [W-1:0]   exp_res;
        bit             exp_to;
        int             exp_lat;
    } vec_t;

    vec_t vecs [9];

    // Winner gets ops, everyone else gets the inverse so a wrong pick shows.
    task automatic run_vec(input vec_t v);
        int n;
        int m;
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            req_data[4*W*i +: 4*W] = (i == v.exp_id) ? v.ops : ~v.ops;
        req      = v.req;
        eng_lat  = v.lat;
        eng_hang = v.hang;
        wait_gnt(n);
        chk("vec_gnt", gnt, 4'b0001 << v.exp_id);
        chk("vec_gnt_latency", n, 1);
        chk("vec_start", mx_start, 1);
        chk("vec_busy", busy, 1);
        chk("vec_X1", mx_X1, v.ops[0*W +: W]);
        chk("vec_X2", mx_X2, v.ops[1*W +: W]);
        chk("vec_X3", mx_X3, v.ops[2*W +: W]);
        chk("vec_X4", mx_X4, v.ops[3*W +: W]);
        req = 4'b0000;
        @(negedge clk);
        chk("vec_gnt_clear", gnt, 0);
        chk("vec_start_clear", mx_start, 0);
        wait_rsp(m);
        chk("vec_rsp_seen", rsp_valid, 1);
        chk("vec_rsp_latency", m + 1, v.exp_lat);
        chk("vec_rsp_id", rsp_id, v.exp_id);
        chk("vec_rsp_result", rsp_result, v.exp_res);
        chk("vec_rsp_timeout", rsp_timeout, v.exp_to);
        @(negedge clk);
        chk("vec_rsp_pulse", rsp_valid, 0);
        chk("vec_idle_busy", busy, 0);
        chk("vec_rsp_hold", rsp_result, v.exp_res);
    endtask

    // Randomized-run reference state
    int           m_ptr;
    bit           m_idle;
    int           idle_cnt;
    bit           pend;
    int           exp_iter;
    int           exp_id;
    logic [W-1:0] exp_res;
    bit           exp_to;

    initial begin
        int n;
        int m;
        int iter;
        int w;
        int lat;
        bit hang;
        logic [3:0] exp_g;
        bit exp_v;
        bit got_rsp;

        vecs[0] = '{4'b0001, {5'd3,  5'd9,  5'd17, 5'd5},  6, 1'b0, 0, 5'd17, 1'b0, 8};
        vecs[1] = '{4'b1111, {5'd1,  5'd2,  5'd20, 5'd4},  2, 1'b0, 1, 5'd20, 1'b0, 4};
        vecs[2] = '{4'b1101, {5'd25, 5'd0,  5'd0,  5'd0},  1, 1'b0, 2, 5'd25, 1'b0, 3};
        vecs[3] = '{4'b1001, {5'd0,  5'd0,  5'd0,  5'd0},  3, 1'b0, 3, 5'd0,  1'b0, 5};
        vecs[4] = '{4'b0110, {5'd7,  5'd7,  5'd7,  5'd7},  1, 1'b1, 1, 5'd0,  1'b1, TO + 1};
        vecs[5] = '{4'b0100, {5'd12, 5'd11, 5'd10, 5'd9},  4, 1'b0, 2, 5'd12, 1'b0, 6};
        vecs[6] = '{4'b0001, {5'd0,  5'd31, 5'd0,  5'd0},  5, 1'b0, 0, 5'd31, 1'b0, 7};
        vecs[7] = '{4'b1000, {5'd8,  5'd9,  5'd6,  5'd5},  7, 1'b0, 3, 5'd9,  1'b0, 9};
        vecs[8] = '{4'b0010, {5'd2,  5'd4,  5'd6,  5'd8},  8, 1'b0, 1, 5'd0,  1'b1, TO + 1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_gnt", gnt, 0);
        chk("reset_busy", busy, 0);
        chk("reset_start", mx_start, 0);
        chk("reset_ops", {mx_X4, mx_X3, mx_X2, mx_X1}, 0);
        chk("reset_rsp", {rsp_valid, rsp_timeout, rsp_id, rsp_result}, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Arrival while busy is not lost: 2 first, then 1, then 2 again
        @(negedge clk);
        req_data[4*W*2 +: 4*W] = {5'd12, 5'd3, 5'd4, 5'd5};
        req_data[4*W*1 +: 4*W] = {5'd1, 5'd2, 5'd3, 5'd27};
        eng_lat = 3; eng_hang = 1'b0;
        req = 4'b0100;
        wait_gnt(n);
        chk("busy_arr_first", gnt, 4'b0100);
        req = 4'b0000;
        @(negedge clk);
        req = 4'b0110;
        wait_rsp(m);
        chk("busy_arr_rsp1", rsp_result, 12);
        wait_gnt(n);
        chk("busy_arr_second", gnt, 4'b0010);
        chk("busy_arr_second_wait", n, 2);
        req[1] = 1'b0;
        wait_rsp(m);
        chk("busy_arr_rsp2_id", rsp_id, 1);
        chk("busy_arr_rsp2", rsp_result, 27);
        wait_gnt(n);
        chk("busy_arr_third", gnt, 4'b0100);
        req[2] = 1'b0;
        wait_rsp(m);
        chk("busy_arr_rsp3", rsp_result, 12);
        @(negedge clk);

        // Stale done in IDLE and in the first WAIT cycle
        stale_force = 1'b1;
        got_rsp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got_rsp = got_rsp | rsp_valid | busy | mx_start;
        end
        chk("stale_idle_quiet", got_rsp, 0);
        req_data[4*W*3 +: 4*W] = {5'd1, 5'd2, 5'd3, 5'd4};
        eng_lat = 2;
        req = 4'b1000;
        wait_gnt(n);
        chk("stale_gnt", gnt, 4'b1000);
        req = 4'b0000;
        @(negedge clk);
        chk("stale_wait0_quiet", rsp_valid, 0);
        stale_force = 1'b0;
        @(negedge clk);
        chk("stale_wait1_quiet", rsp_valid, 0);
        wait_rsp(m);
        chk("stale_rsp_latency", m + 2, 4);
        chk("stale_rsp_result", rsp_result, 4);
        chk("stale_rsp_timeout", rsp_timeout, 0);
        @(negedge clk);

        // Asynchronous reset in WAIT abandons the transaction
        req_data[4*W*1 +: 4*W] = {5'd9, 5'd9, 5'd9, 5'd9};
        eng_hang = 1'b1;
        req = 4'b0010;
        wait_gnt(n);
        chk("rstw_gnt", gnt, 4'b0010);
        req = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstw_busy", busy, 0);
        chk("rstw_ops", {mx_X4, mx_X3, mx_X2, mx_X1}, 0);
        chk("rstw_rsp", {rsp_valid, rsp_timeout, rsp_id, rsp_result}, 0);
        chk("rstw_gnt_start", {gnt, mx_start}, 0);
        got_rsp = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            got_rsp = got_rsp | rsp_valid;
        end
        chk("rstw_no_rsp", got_rsp, 0);
        rst = 1'b1;
        req_data[4*W*0 +: 4*W] = {5'd2, 5'd2, 5'd2, 5'd2};
        req_data[4*W*3 +: 4*W] = {5'd6, 5'd6, 5'd6, 5'd6};
        eng_hang = 1'b0; eng_lat = 1;
        req = 4'b1001;
        wait_gnt(n);
        chk("rstw_first_after", gnt, 4'b0001);
        req[0] = 1'b0;
        wait_rsp(m);
        chk("rstw_rsp0", rsp_result, 2);
        wait_gnt(n);
        chk("rstw_second_after", gnt, 4'b1000);
        req[3] = 1'b0;
        wait_rsp(m);
        chk("rstw_rsp3", rsp_result, 6);

        // Randomized traffic against the reference model
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b1;
        m_ptr = 3; m_idle = 1'b1; idle_cnt = 0; pend = 1'b0; exp_iter = 0;
        iter = 0;
        while (iter < 700) begin
            @(negedge clk);
            iter++;
            if (idle_cnt > 0) begin
                idle_cnt--;
                if (idle_cnt == 0) m_idle = 1'b1;
            end
            exp_g = 4'b0000;
            w = 0;
            if (m_idle && req != 4'b0000) begin
                w = rr_pick(req, m_ptr);
                exp_g = 4'b0001 << w;
            end
            chk("rnd_gnt", gnt, exp_g);
            chk("rnd_start", mx_start, exp_g != 4'b0000);
            if (exp_g != 4'b0000) begin
                m_idle = 1'b0;
                m_ptr = w;
                chk("rnd_ops", {mx_X4, mx_X3, mx_X2, mx_X1}, req_data[4*W*w +: 4*W]);
                lat = $urandom_range(1, 7);
                hang = ($urandom_range(0, 7) == 0);
                eng_lat = lat;
                eng_hang = hang;
                pend = 1'b1;
                exp_iter = iter + (hang ? TO + 1 : lat + 2);
                exp_id = w;
                exp_res = hang ? '0 : max4(req_data[4*W*w +: 4*W]);
                exp_to = hang;
            end
            exp_v = pend && (iter == exp_iter);
            chk("rnd_rsp_valid", rsp_valid, exp_v);
            if (exp_v) begin
                chk("rnd_rsp_id", rsp_id, exp_id);
                chk("rnd_rsp_result", rsp_result, exp_res);
                chk("rnd_rsp_timeout", rsp_timeout, exp_to);
                $display("[TB] rnd response id=%0d result=%0d timeout=%0d", rsp_id, rsp_result, rsp_timeout);
                pend = 1'b0;
                idle_cnt = 2;
            end
            for (int i = 0; i < 4; i++) begin
                if (req[i] && gnt[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && iter < 500 && $urandom_range(0, 3) == 0) begin
                    req_data[4*W*i +: 4*W] = 20'($urandom);
                    req[i] = 1'b1;
                end
            end
            if (iter >= 500 && !pend && req == 4'b0000 && m_idle) break;
        end
        chk("rnd_drained", {pend, req}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

endmodule
